vjtag_dr_sync: RTL and testbench

Downstream companion of the virtual-JTAG IR decoder on the DE0-Nano. It oversamples the vJTAG megafunction outputs (tck, tdi, virtual_state_sdr, virtual_state_udr, ir_in) in the CLOCK_50 domain, deserialises the DR scan into a parallel word and drives tdo from a readback word. Each completed Update-DR becomes one {ir, data, length} command handed to user logic through a valid/ready handshake. It replaces raw `posedge CMDx` clocking with a single-clock, synchronous design.

---
 rtl/vjtag_pkg.sv | 18 +
 rtl/vjtag_sync_edge.sv | 37 +++
 rtl/vjtag_dr_sync.sv | 153 +++++++++++++++
 tb/tb_vjtag_dr_sync.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vjtag_pkg.sv
// Shared constants and types for the virtual-JTAG DR oversampler.
package vjtag_pkg;

   localparam int DW_DEFAULT  = 8;
   localparam int IRW_DEFAULT = 3;
   localparam int LEN_W       = $clog2(DW_DEFAULT + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Width of a bit counter that must reach dw inclusive.
   function automatic int len_width(input int dw);
      return $clog2(dw + 1);
   endfunction

endpackage

// File: rtl/vjtag_sync_edge.sv
// Multi-flop synchroniser with registered history for rise/fall detection.
module vjtag_sync_edge #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              hist;
   logic [STAGES:0]   fill;
   logic              primed;

   always_ff @(posedge clk) begin
      if (reset) begin
         chain <= '0;
         hist  <= 1'b0;
         fill  <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
         hist  <= chain[STAGES-1];
         fill  <= {fill[STAGES-1:0], 1'b1};
      end
   end

   // Edges are masked until chain and history hold real pin samples, so a
   // level already high at reset release is not mistaken for a fresh edge.
   assign primed = fill[STAGES];
   assign q      = chain[STAGES-1];
   assign rise   = primed & q & ~hist;
   assign fall   = primed & ~q & hist;

endmodule

// File: rtl/vjtag_dr_sync.sv
// Oversamples vJTAG DR-scan signals in the CLOCK_50 domain, deserialises the
// scan and hands each Update-DR to user logic as a valid/ready command.
module vjtag_dr_sync
   import vjtag_pkg::*;
#(
   parameter int DW          = DW_DEFAULT,
   parameter int IRW         = IRW_DEFAULT,
   parameter int SYNC_STAGES = 2
) (
   input  logic                      CLOCK_50,
   input  logic                      reset,
   input  logic                      jtag_tck,
   input  logic                      jtag_tdi,
   input  logic                      jtag_sdr,
   input  logic                      jtag_udr,
   input  logic [IRW-1:0]            jtag_ir_in,
   output logic                      jtag_tdo,
   input  logic [DW-1:0]             rd_data,
   output logic                      cmd_valid,
   input  logic                      cmd_ready,
   output logic [IRW-1:0]            cmd_ir,
   output logic [DW-1:0]             cmd_data,
   output logic [$clog2(DW+1)-1:0]   cmd_len,
   output logic                      overflow
);

   localparam int LW = len_width(DW);

   logic tck_q, tck_rise, tck_fall;
   logic sdr_q, sdr_rise, sdr_fall;
   logic udr_q, udr_rise, udr_fall;

   vjtag_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_tck (
      .clk(CLOCK_50), .reset(reset), .d(jtag_tck),
      .q(tck_q), .rise(tck_rise), .fall(tck_fall)
   );

   vjtag_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdr (
      .clk(CLOCK_50), .reset(reset), .d(jtag_sdr),
      .q(sdr_q), .rise(sdr_rise), .fall(sdr_fall)
   );

   vjtag_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_udr (
      .clk(CLOCK_50), .reset(reset), .d(jtag_udr),
      .q(udr_q), .rise(udr_rise), .fall(udr_fall)
   );

   logic unused_sync;
   assign unused_sync = ^{tck_q, tck_fall, sdr_q, udr_q, udr_fall};

   // Same depth as the tck chain so tdi_s is valid in the tck_rise cycle.
   logic [SYNC_STAGES-1:0] tdi_chain;
   logic [IRW-1:0]         ir_chain [SYNC_STAGES];
   logic                   tdi_s;
   logic [IRW-1:0]         ir_s;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         tdi_chain <= '0;
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            ir_chain[i] <= '0;
         end
      end else begin
         tdi_chain   <= {tdi_chain[SYNC_STAGES-2:0], jtag_tdi};
         ir_chain[0] <= jtag_ir_in;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            ir_chain[i] <= ir_chain[i-1];
         end
      end
   end

   assign tdi_s = tdi_chain[SYNC_STAGES-1];
   assign ir_s  = ir_chain[SYNC_STAGES-1];

   state_t        state_q, state_d;
   logic          load_en, shift_en;
   logic [DW-1:0] shreg;
   logic [LW-1:0] bitcnt;
   logic          udr_rise_q;
   logic          slot_free;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      load_en  = 1'b0;
      shift_en = 1'b0;
      case (state_q)
         IDLE: begin
            if (sdr_rise) begin
               state_d = SHIFT;
               load_en = 1'b1;
            end
         end
         SHIFT: begin
            shift_en = tck_rise;
            if (sdr_fall) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         shreg  <= '0;
         bitcnt <= '0;
      end else if (load_en) begin
         shreg  <= rd_data;
         bitcnt <= '0;
      end else if (shift_en) begin
         shreg  <= {tdi_s, shreg[DW-1:1]};
         bitcnt <= (bitcnt == LW'(DW)) ? bitcnt : bitcnt + 1'b1;
      end
   end

   assign jtag_tdo  = shreg[0];
   assign slot_free = ~cmd_valid | cmd_ready;

   // The extra udr stage lets a shift landing in the same cycle settle first.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         udr_rise_q <= 1'b0;
         cmd_valid  <= 1'b0;
         cmd_ir     <= '0;
         cmd_data   <= '0;
         cmd_len    <= '0;
         overflow   <= 1'b0;
      end else begin
         udr_rise_q <= udr_rise;
         if (udr_rise_q) begin
            if (slot_free) begin
               cmd_ir    <= ir_s;
               cmd_data  <= shreg;
               cmd_len   <= bitcnt;
               cmd_valid <= 1'b1;
            end else begin
               overflow <= 1'b1;
            end
         end else if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_vjtag_dr_sync.sv
// Directed bench for vjtag_dr_sync with a queue of expected commands.
module tb_vjtag_dr_sync;

   localparam int SYNC = 2;

   typedef struct {
      logic [2:0] ir;
      logic [7:0] data;
      logic [3:0] len;
   } cmd_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       jtag_tck, jtag_tdi, jtag_sdr, jtag_udr;
   logic [2:0] jtag_ir_in;
   logic       jtag_tdo;
   logic [7:0] rd_data;
   logic       cmd_valid, cmd_ready;
   logic [2:0] cmd_ir;
   logic [7:0] cmd_data;
   logic [3:0] cmd_len;
   logic       overflow;

   int   errors = 0;
   int   checks = 0;
   cmd_t exp_q[$];

   always #10 clk = ~clk;

   vjtag_dr_sync #(.DW(8), .IRW(3), .SYNC_STAGES(SYNC)) dut (
      .CLOCK_50(clk), .reset(reset),
      .jtag_tck(jtag_tck), .jtag_tdi(jtag_tdi), .jtag_sdr(jtag_sdr),
      .jtag_udr(jtag_udr), .jtag_ir_in(jtag_ir_in), .jtag_tdo(jtag_tdo),
      .rd_data(rd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_ir(cmd_ir), .cmd_data(cmd_data), .cmd_len(cmd_len),
      .overflow(overflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tck_bit(input logic b);
      jtag_tdi = b;
      cyc(1);
      jtag_tck = 1'b1;
      cyc(5);
      jtag_tck = 1'b0;
      cyc(5);
   endtask

   task automatic sdr_start(input logic [7:0] r, input logic [2:0] ir);
      rd_data    = r;
      jtag_ir_in = ir;
      jtag_sdr   = 1'b1;
      cyc(6);
   endtask

   task automatic sdr_end();
      jtag_sdr = 1'b0;
      cyc(6);
   endtask

   task automatic scan(input logic [7:0] r, input logic [15:0] v, input int n,
                       input logic [2:0] ir);
      sdr_start(r, ir);
      for (int i = 0; i < n; i++) tck_bit(v[i]);
      sdr_end();
   endtask

   task automatic udr_pulse();
      jtag_udr = 1'b1;
      cyc(6);
      jtag_udr = 1'b0;
      cyc(6);
   endtask

   // Register contents after n LSB-first shifts of v into a word loaded with r.
   function automatic logic [7:0] model(input logic [7:0] r, input logic [15:0] v,
                                        input int n);
      logic [23:0] t;
      t = {v, r} >> n;
      return t[7:0];
   endfunction

   task automatic push(input logic [2:0] ir, input logic [7:0] data, input logic [3:0] len);
      cmd_t c;
      c.ir = ir; c.data = data; c.len = len;
      exp_q.push_back(c);
   endtask

   task automatic cmp_front(input string tag);
      cmd_t c;
      chk({tag, "_sb"}, 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
         c = exp_q.pop_front();
         chk({tag, "_ir"}, cmd_ir, c.ir);
         chk({tag, "_data"}, cmd_data, c.data);
         chk({tag, "_len"}, cmd_len, c.len);
      end
   endtask

   task automatic check_cmd(input string tag);
      for (int k = 0; k < 20 && !cmd_valid; k++) cyc(1);
      chk({tag, "_valid"}, cmd_valid, 1);
      if (cmd_valid) begin
         cmp_front(tag);
         cmd_ready = 1'b1;
         cyc(1);
         cmd_ready = 1'b0;
         chk({tag, "_drain"}, cmd_valid, 0);
      end
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] r;
      logic [7:0] prev;
      reset = 1'b1; jtag_tck = 0; jtag_tdi = 0; jtag_sdr = 0; jtag_udr = 0;
      jtag_ir_in = '0; rd_data = '0; cmd_ready = 0;
      cyc(4);
      reset = 1'b0;
      cyc(1);
      chk("rst_tdo", jtag_tdo, 0);
      chk("rst_valid", cmd_valid, 0);
      chk("rst_data", cmd_data, 0);
      chk("rst_ovf", overflow, 0);
      cyc(5);

      // Basic scan: readback A5 shifts out while 3C shifts in
      r = 8'hA5;
      sdr_start(r, 3'b101);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("tdo_bit%0d", i), jtag_tdo, r[i]);
         tck_bit(1'(8'h3C >> i));
      end
      chk("tdo_final", jtag_tdo, 0);
      sdr_end();
      push(3'd5, 8'h3C, 4'd8);
      jtag_udr = 1'b1;
      cyc(SYNC + 1);
      chk("lat_early", cmd_valid, 0);
      cyc(1);
      chk("lat_on", cmd_valid, 1);
      cyc(4);
      jtag_udr = 1'b0;
      cyc(6);
      check_cmd("basic");

      // Over-length: 11 bits, only the last 8 remain
      scan(8'h00, 16'h05B3, 11, 3'b010);
      push(3'd2, model(8'h00, 16'h05B3, 11), 4'd8);
      udr_pulse();
      check_cmd("long");

      // Short: 3 bits
      scan(8'hF0, 16'h0005, 3, 3'b001);
      prev = model(8'hF0, 16'h0005, 3);
      push(3'd1, prev, 4'd3);
      udr_pulse();
      check_cmd("short");

      // tck while sdr low must not disturb shreg/bitcnt
      tck_bit(1'b1); tck_bit(1'b1); tck_bit(1'b0);
      chk("idle_tdo", jtag_tdo, prev[0]);
      push(3'd1, prev, 4'd3);
      udr_pulse();
      check_cmd("idle");

      // Zero-bit scan
      scan(8'h69, 16'h0000, 0, 3'b110);
      push(3'd6, 8'h69, 4'd0);
      udr_pulse();
      check_cmd("zero");

      // Refill in the same cycle as the consumer accepts
      scan(8'h11, 16'h00C7, 8, 3'b011);
      push(3'd3, 8'hC7, 4'd8);
      udr_pulse();
      scan(8'h22, 16'h0055, 8, 3'b100);
      push(3'd4, 8'h55, 4'd8);
      jtag_udr = 1'b1;
      cyc(SYNC + 1);
      cmp_front("simA");
      cmd_ready = 1'b1;
      cyc(1);
      cmd_ready = 1'b0;
      chk("sim_valid", cmd_valid, 1);
      chk("sim_ovf", overflow, 0);
      cyc(4);
      jtag_udr = 1'b0;
      cyc(6);
      check_cmd("simB");

      // Back-pressure: second command dropped
      scan(8'h00, 16'h0081, 8, 3'b111);
      push(3'd7, 8'h81, 4'd8);
      udr_pulse();
      scan(8'h00, 16'h007E, 8, 3'b000);
      udr_pulse();
      chk("bp_ovf", overflow, 1);
      check_cmd("bp");
      cyc(3);
      chk("bp_ovf_sticky", overflow, 1);

      // Reset mid-scan with a command held
      scan(8'h00, 16'h000F, 8, 3'b001);
      udr_pulse();
      sdr_start(8'hA5, 3'b010);
      tck_bit(1'b1);
      tck_bit(1'b0);
      reset = 1'b1;
      cyc(4);
      reset = 1'b0;
      cyc(1);
      chk("mr_tdo", jtag_tdo, 0);
      chk("mr_valid", cmd_valid, 0);
      chk("mr_ir", cmd_ir, 0);
      chk("mr_data", cmd_data, 0);
      chk("mr_len", cmd_len, 0);
      chk("mr_ovf", overflow, 0);
      tck_bit(1'b1); tck_bit(1'b1); tck_bit(1'b1);
      chk("mr_tdo_hold", jtag_tdo, 0);
      chk("mr_valid_hold", cmd_valid, 0);
      sdr_end();
      scan(8'h5A, 16'h00C3, 8, 3'b010);
      push(3'd2, 8'hC3, 4'd8);
      udr_pulse();
      check_cmd("post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
